button_counter_bank: RTL and testbench
======================================

BUTTON_COUNTER_BANK -- requirements
Module: button_counter_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent counter channels, 1..16.
REQ-002 Parameter CW, default 16: counter width in bits, 2..32.
REQ-003 Parameter DB_CYCLES, default 1000: clk cycles a button level must hold before acceptance, >=1.
REQ-004 Parameter SAT, default 0: 0 = wrap-around counting, 1 = saturating counting.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port btn_up, input, NCH: raw asynchronous increment buttons, bit i for channel i.
REQ-008 Port btn_dn, input, NCH: raw asynchronous decrement buttons, bit i for channel i.
REQ-009 Port clr, input, NCH: synchronous per-channel clear, not debounced.
REQ-010 Port count, output, NCH*CW: channel i value at bits [i*CW +: CW].
REQ-011 Port evt, output, NCH: one-cycle pulse when channel i count changed that cycle.

Function
REQ-012 Each btn_up/btn_dn bit passes through a 2-flop synchroniser.
REQ-013 Debounced level toggles only after the synchronised level differs from it for DB_CYCLES consecutive cycles; any agreeing cycle restarts the run counter at 0.
REQ-014 A debounced 0->1 transition produces a one-cycle press pulse; release (1->0) produces nothing.
REQ-015 Latency: a clean press stable from edge N updates count on edge N+DB_CYCLES+3; evt is high in the cycle following that edge.
REQ-016 Up pulse only: count+1; down pulse only: count-1; both in the same cycle: no change, no evt.
REQ-017 clr[i] high: count[i] becomes 0 on the next edge, overriding any coincident pulse; evt[i] asserts only if the prior value was non-zero.
REQ-018 SAT=0: max+1 -> 0, 0-1 -> max, evt asserted.
REQ-019 SAT=1: up at max and down at 0 leave the count unchanged, evt not asserted.
REQ-020 Channels are fully independent; no shared arithmetic or arbitration.
REQ-021 A button held through reset deassertion counts exactly once, DB_CYCLES+3 edges after the first post-reset edge.

Reset
REQ-022 rst asserted: all counts 0, evt 0, synchronisers 0, debounced levels 0, run counters 0, ovf 0 (when present); takes effect immediately, no clock required.
REQ-023 rst mid-debounce discards the partial run; no pulse is produced from pre-reset history.

Configuration
REQ-024 Macro BTN_CNT_OVF_FLAG_EN defined: output port ovf, NCH wide, is added; ovf[i] sets (sticky) when an up pulse occurs at max or a down pulse occurs at 0, in either mode; it clears on clr[i] or rst, and clr wins over a coincident set.
REQ-025 Macro undefined: no ovf port and no ovf logic; all other behaviour is identical.

Structure
REQ-026 Package button_counter_pkg holds default parameter constants, and a function computing the run-counter width as $clog2(DB_CYCLES+1).
REQ-027 Sub-module button_debounce (synchroniser, debouncer, press-pulse) is instantiated 2*NCH times; counter and flag logic sit in the top module.
REQ-028 No derived clocks: every flop uses clk and rst only.

Verification (NCH=2, CW=4, DB_CYCLES=4)
REQ-029 Clean press of btn_up[0] for 10 cycles -> count[0] 0->1 exactly 7 edges after the press; evt[0] pulses once; count[1] stays 0.
REQ-030 btn_up[0] bounce 1,0,1,0, then stable 1 -> a single increment after the stable run; bursts shorter than 4 cycles never count.
REQ-031 SAT=0: 15 presses then 1 more -> count[0]=15, then 0 (ovf[0]=1 if enabled); SAT=1: 16 presses -> 15, no evt on the 16th.
REQ-032 Simultaneous debounced up and down pulses on ch1 at count=5 -> stays 5, evt[1]=0; clr[1] coincident with an up pulse at 5 -> 0.
REQ-033 rst pulsed 2 cycles into a debounce run with btn held -> all outputs 0 at once; after release, the held button counts once, 7 edges after the first post-reset edge.
REQ-034 BTN_CNT_OVF_FLAG_EN defined: down press at 0 (SAT=1) -> ovf[0]=1, count stays 0; clr[0] -> ovf[0]=0 on the next edge.

Source files
------------

// File: rtl/button_counter_pkg.sv
// Shared defaults and sizing helpers for the button counter bank.
package button_counter_pkg;

  localparam int DEF_NCH       = 4;
  localparam int DEF_CW        = 16;
  localparam int DEF_DB_CYCLES = 1000;
  localparam int DEF_SAT       = 0;

  // The run counter must be able to hold values up to DB_CYCLES.
  function automatic int run_cnt_width(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button input: 2-flop synchroniser, run-length debouncer and a
// registered one-cycle press pulse on each debounced 0->1 transition.
module button_debounce
  import button_counter_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int RCW = run_cnt_width(DB_CYCLES);
  localparam logic [RCW-1:0] LAST = RCW'(DB_CYCLES - 1);

  logic [1:0]     sync_q;
  logic           db_q;
  logic           db_d_q;
  logic [RCW-1:0] run_q;

  // The level flips on the DB_CYCLES-th consecutive disagreeing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      db_d_q <= 1'b0;
      run_q  <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      db_d_q <= db_q;
      press  <= db_q & ~db_d_q;
      if (sync_q[1] != db_q) begin
        if (run_q == LAST) begin
          db_q  <= sync_q[1];
          run_q <= '0;
        end else begin
          run_q <= run_q + RCW'(1);
        end
      end else begin
        run_q <= '0;
      end
    end
  end

endmodule

// File: rtl/button_counter_bank.sv
// Bank of NCH independent debounced up/down counters with per-channel clear.
// Optional sticky overflow flags are enabled by defining BTN_CNT_OVF_FLAG_EN.
module button_counter_bank
  import button_counter_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int CW        = DEF_CW,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int SAT       = DEF_SAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    btn_up,
  input  logic [NCH-1:0]    btn_dn,
  input  logic [NCH-1:0]    clr,
  output logic [NCH*CW-1:0] count,
`ifdef BTN_CNT_OVF_FLAG_EN
  output logic [NCH-1:0]    ovf,
`endif
  output logic [NCH-1:0]    evt
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          up_p;
    logic          dn_p;
    logic [CW-1:0] cnt_q;
    logic          evt_q;
    logic          at_max;
    logic          at_zero;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_up (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_up[i]),
      .press (up_p)
    );

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_dn (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_dn[i]),
      .press (dn_p)
    );

    assign at_max  = (cnt_q == {CW{1'b1}});
    assign at_zero = (cnt_q == '0);

    // Clear dominates; coincident up and down presses cancel out.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        evt_q <= 1'b0;
      end else if (clr[i]) begin
        cnt_q <= '0;
        evt_q <= !at_zero;
      end else if (up_p && !dn_p) begin
        if (at_max && SAT != 0) begin
          evt_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
          evt_q <= 1'b1;
        end
      end else if (dn_p && !up_p) begin
        if (at_zero && SAT != 0) begin
          evt_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - CW'(1);
          evt_q <= 1'b1;
        end
      end else begin
        evt_q <= 1'b0;
      end
    end

    assign count[i*CW +: CW] = cnt_q;
    assign evt[i]            = evt_q;

`ifdef BTN_CNT_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ovf_q <= 1'b0;
      end else if (clr[i]) begin
        ovf_q <= 1'b0;
      end else if ((up_p && !dn_p && at_max) || (dn_p && !up_p && at_zero)) begin
        ovf_q <= 1'b1;
      end
    end

    assign ovf[i] = ovf_q;
`endif
  end

endmodule

// File: tb/tb_button_counter_bank.sv
// Directed bench: a wrapping (SAT=0) and a saturating (SAT=1) bank share stimulus.
module tb_button_counter_bank;

  localparam int NCH = 2;
  localparam int CW  = 4;
  localparam int DB  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_up, btn_dn, clr;
  logic [7:0] count_a, count_b;
  logic [1:0] evt_a, evt_b;
`ifdef BTN_CNT_OVF_FLAG_EN
  logic [1:0] ovf_a, ovf_b;
`endif

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  button_counter_bank #(.NCH(NCH), .CW(CW), .DB_CYCLES(DB), .SAT(0)) dut_a (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
    .count(count_a),
`ifdef BTN_CNT_OVF_FLAG_EN
    .ovf(ovf_a),
`endif
    .evt(evt_a)
  );

  button_counter_bank #(.NCH(NCH), .CW(CW), .DB_CYCLES(DB), .SAT(1)) dut_b (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
    .count(count_b),
`ifdef BTN_CNT_OVF_FLAG_EN
    .ovf(ovf_b),
`endif
    .evt(evt_b)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Channel ch of both banks: counts and evt bits.
  task automatic checkChan(input string tag, input int ch,
                           input logic [3:0] ca, input logic ea,
                           input logic [3:0] cb, input logic eb);
    checkOutput({tag, "_cnt_a"}, 32'(count_a[ch*4 +: 4]), 32'(ca));
    checkOutput({tag, "_evt_a"}, 32'(evt_a[ch]), 32'(ea));
    checkOutput({tag, "_cnt_b"}, 32'(count_b[ch*4 +: 4]), 32'(cb));
    checkOutput({tag, "_evt_b"}, 32'(evt_b[ch]), 32'(eb));
  endtask

  task automatic checkOvf(input string tag, input logic [1:0] oa, input logic [1:0] ob);
`ifdef BTN_CNT_OVF_FLAG_EN
    checkOutput({tag, "_ovf_a"}, 32'(ovf_a), 32'(oa));
    checkOutput({tag, "_ovf_b"}, 32'(ovf_b), 32'(ob));
`else
    if (oa != ob) $display("[TB] note %s: flags differ between modes", tag);
`endif
  endtask

  // Clean press: held long enough to count, then released and settled.
  task automatic pressBtn(input bit up, input int ch);
    if (up) btn_up[ch] = 1'b1; else btn_dn[ch] = 1'b1;
    tick(8);
    btn_up[ch] = 1'b0;
    btn_dn[ch] = 1'b0;
    tick(8);
  endtask

  initial begin
    rst    = 1'b1;
    btn_up = '0;
    btn_dn = '0;
    clr    = '0;
    #3;
    checkOutput("reset_count_a", 32'(count_a), 32'h0);
    checkOutput("reset_count_b", 32'(count_b), 32'h0);
    checkOutput("reset_evt", 32'({evt_a, evt_b}), 32'h0);
    checkOvf("reset", 2'b00, 2'b00);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Clean press of up[0]: count moves on the 8th edge after driving.
    btn_up[0] = 1'b1;
    tick(7);
    checkChan("press_before", 0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick(1);
    checkChan("press_edge", 0, 4'd1, 1'b1, 4'd1, 1'b1);
    checkChan("press_other", 1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick(1);
    checkChan("press_after", 0, 4'd1, 1'b0, 4'd1, 1'b0);
    tick(1);
    btn_up[0] = 1'b0;
    tick(10);
    checkChan("release", 0, 4'd1, 1'b0, 4'd1, 1'b0);

    // Bounce 1,0,1,0 then stable 1.
    for (int k = 0; k < 4; k++) begin
      btn_up[0] = (k % 2 == 0);
      tick(1);
    end
    btn_up[0] = 1'b1;
    tick(7);
    checkChan("bounce_before", 0, 4'd1, 1'b0, 4'd1, 1'b0);
    tick(1);
    checkChan("bounce_edge", 0, 4'd2, 1'b1, 4'd2, 1'b1);
    btn_up[0] = 1'b0;
    tick(10);

    // A 3-cycle burst is too short to be accepted.
    btn_up[0] = 1'b1;
    tick(3);
    btn_up[0] = 1'b0;
    tick(12);
    checkChan("short_burst", 0, 4'd2, 1'b0, 4'd2, 1'b0);

    // Clear from non-zero pulses evt; clear at zero does not.
    clr[0] = 1'b1;
    tick(1);
    checkChan("clr_nonzero", 0, 4'd0, 1'b1, 4'd0, 1'b1);
    tick(1);
    checkChan("clr_zero", 0, 4'd0, 1'b0, 4'd0, 1'b0);
    clr[0] = 1'b0;

    // Count up to max, then one more press.
    for (int k = 1; k <= 15; k++) pressBtn(1'b1, 0);
    checkChan("at_max", 0, 4'd15, 1'b0, 4'd15, 1'b0);
    checkOvf("at_max", 2'b00, 2'b00);
    btn_up[0] = 1'b1;
    tick(7);
    checkChan("max_before", 0, 4'd15, 1'b0, 4'd15, 1'b0);
    tick(1);
    checkChan("max_plus1", 0, 4'd0, 1'b1, 4'd15, 1'b0);
    checkOvf("max_plus1", 2'b01, 2'b01);
    btn_up[0] = 1'b0;
    tick(8);

    // Channel 1 to 5, then simultaneous up and down.
    for (int k = 1; k <= 5; k++) pressBtn(1'b1, 1);
    checkChan("ch1_five", 1, 4'd5, 1'b0, 4'd5, 1'b0);
    btn_up[1] = 1'b1;
    btn_dn[1] = 1'b1;
    tick(8);
    checkChan("both_edge", 1, 4'd5, 1'b0, 4'd5, 1'b0);
    tick(1);
    checkChan("both_after", 1, 4'd5, 1'b0, 4'd5, 1'b0);
    btn_up[1] = 1'b0;
    btn_dn[1] = 1'b0;
    tick(8);

    // Clear coincident with an up pulse wins.
    btn_up[1] = 1'b1;
    tick(7);
    clr[1] = 1'b1;
    tick(1);
    checkChan("clr_vs_up", 1, 4'd0, 1'b1, 4'd0, 1'b1);
    clr[1] = 1'b0;
    btn_up[1] = 1'b0;
    tick(8);

    // Down at zero on channel 1: wraps vs. saturates.
    btn_dn[1] = 1'b1;
    tick(8);
    checkChan("dn_at_zero", 1, 4'd15, 1'b1, 4'd0, 1'b0);
    checkOvf("dn_at_zero", 2'b11, 2'b11);
    btn_dn[1] = 1'b0;
    tick(8);

    // Channel 0: clear flags, down at zero, then clear again.
    clr[0] = 1'b1;
    tick(1);
    checkChan("clr0_a", 0, 4'd0, 1'b0, 4'd0, 1'b1);
    checkOvf("clr0_a", 2'b10, 2'b10);
    clr[0] = 1'b0;
    pressBtn(1'b0, 0);
    checkChan("dn0", 0, 4'd15, 1'b0, 4'd0, 1'b0);
    checkOvf("dn0", 2'b11, 2'b11);
    clr[0] = 1'b1;
    tick(1);
    checkChan("clr0_b", 0, 4'd0, 1'b1, 4'd0, 1'b0);
    checkOvf("clr0_b", 2'b10, 2'b10);
    clr[0] = 1'b0;
    tick(2);

    // Reset mid-debounce with the button held.
    btn_up[0] = 1'b1;
    tick(4);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_count_a", 32'(count_a), 32'h0);
    checkOutput("midrst_count_b", 32'(count_b), 32'h0);
    checkOutput("midrst_evt", 32'({evt_a, evt_b}), 32'h0);
    checkOvf("midrst", 2'b00, 2'b00);
    tick(2);
    rst = 1'b0;
    tick(7);
    checkChan("post_rst_before", 0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick(1);
    checkChan("post_rst_edge", 0, 4'd1, 1'b1, 4'd1, 1'b1);
    tick(12);
    checkChan("post_rst_hold", 0, 4'd1, 1'b0, 4'd1, 1'b0);
    btn_up[0] = 1'b0;
    tick(8);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
